// File: rtl/icb_dma_copy.sv
// icb_dma_copy: single-channel word copy engine on an ICB master port.
// Reads one WIDTH-bit word from the source, writes it to the destination,
// and repeats for len words with one bus transaction in flight at a time.
// Optional build macro: ICB_DMA_ERR_ABORT_EN -- when defined, a read response
// carrying rsp_err aborts the copy (no write) and reports err with done.
module icb_dma_copy #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [15:0]          len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 m_icb_cmd_valid,
  input  logic                 m_icb_cmd_ready,
  output logic [ADDR_W-1:0]    m_icb_cmd_addr,
  output logic                 m_icb_cmd_read,
  output logic [WIDTH-1:0]     m_icb_cmd_wdata,
  output logic [WIDTH/8-1:0]   m_icb_cmd_wmask,
  input  logic                 m_icb_rsp_valid,
  output logic                 m_icb_rsp_ready,
  input  logic [WIDTH-1:0]     m_icb_rsp_rdata,
  input  logic                 m_icb_rsp_err
);

  localparam int BYTES = WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    WR_CMD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [15:0]         remain_q, remain_d;
  logic [WIDTH-1:0]    data_q, data_d;

`ifdef ICB_DMA_ERR_ABORT_EN
  logic                err_q, err_d;
`else
  // Response error is deliberately ignored in this build.
  logic                unused_rsp_err;
  assign unused_rsp_err = m_icb_rsp_err;
`endif

  // State and datapath registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      data_q   <= '0;
`ifdef ICB_DMA_ERR_ABORT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
      data_q   <= data_d;
`ifdef ICB_DMA_ERR_ABORT_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state logic: sequencing of read, wait, write per word.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    data_d   = data_q;
`ifdef ICB_DMA_ERR_ABORT_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ICB_DMA_ERR_ABORT_EN
          err_d = 1'b0;
`endif
          if (len != 16'd0) begin
            src_d    = src_addr;
            dst_d    = dst_addr;
            remain_d = len;
            state_d  = RD_CMD;
          end else begin
            state_d  = DONE;
          end
        end
      end
      RD_CMD: begin
        if (m_icb_cmd_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (m_icb_rsp_valid) begin
`ifdef ICB_DMA_ERR_ABORT_EN
          if (m_icb_rsp_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            data_d  = m_icb_rsp_rdata;
            state_d = WR_CMD;
          end
`else
          data_d  = m_icb_rsp_rdata;
          state_d = WR_CMD;
`endif
        end
      end
      WR_CMD: begin
        if (m_icb_cmd_ready) begin
          if (remain_q == 16'd1) begin
            state_d = DONE;
          end else begin
            remain_d = remain_q - 16'd1;
            // Address arithmetic wraps naturally at ADDR_W bits.
            src_d    = src_q + ADDR_W'(BYTES);
            dst_d    = dst_q + ADDR_W'(BYTES);
            state_d  = RD_CMD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: bus fields are driven only in their command states and
  // are zero elsewhere, so they stay stable while a command is stalled.
  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    m_icb_cmd_valid = 1'b0;
    m_icb_cmd_read  = 1'b0;
    m_icb_cmd_addr  = '0;
    m_icb_cmd_wdata = '0;
    m_icb_cmd_wmask = '0;
    m_icb_rsp_ready = 1'b0;
    unique case (state_q)
      RD_CMD: begin
        busy            = 1'b1;
        m_icb_cmd_valid = 1'b1;
        m_icb_cmd_read  = 1'b1;
        m_icb_cmd_addr  = src_q;
      end
      RD_WAIT: begin
        busy            = 1'b1;
        m_icb_rsp_ready = 1'b1;
      end
      WR_CMD: begin
        busy            = 1'b1;
        m_icb_cmd_valid = 1'b1;
        m_icb_cmd_addr  = dst_q;
        m_icb_cmd_wdata = data_q;
        m_icb_cmd_wmask = '1;
      end
      DONE: begin
        done = 1'b1;
`ifdef ICB_DMA_ERR_ABORT_EN
        err  = err_q;
`endif
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_icb_dma_copy.sv
// Self-checking bench for icb_dma_copy: a cycle-stepped ICB slave with
// memory, a word-level reference model of the copy, and directed plus
// randomized transfers.
module tb_icb_dma_copy;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 32;
  localparam int BYTES  = WIDTH / 8;
  localparam int LIMIT  = 3000;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [31:0]       src_addr, dst_addr;
  logic [15:0]       len;
  logic              busy, done, err;
  logic              m_icb_cmd_valid, m_icb_cmd_ready;
  logic [31:0]       m_icb_cmd_addr;
  logic              m_icb_cmd_read;
  logic [31:0]       m_icb_cmd_wdata;
  logic [3:0]        m_icb_cmd_wmask;
  logic              m_icb_rsp_valid, m_icb_rsp_ready;
  logic [31:0]       m_icb_rsp_rdata;
  logic              m_icb_rsp_err;

  icb_dma_copy #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .len             (len),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .m_icb_cmd_valid (m_icb_cmd_valid),
    .m_icb_cmd_ready (m_icb_cmd_ready),
    .m_icb_cmd_addr  (m_icb_cmd_addr),
    .m_icb_cmd_read  (m_icb_cmd_read),
    .m_icb_cmd_wdata (m_icb_cmd_wdata),
    .m_icb_cmd_wmask (m_icb_cmd_wmask),
    .m_icb_rsp_valid (m_icb_rsp_valid),
    .m_icb_rsp_ready (m_icb_rsp_ready),
    .m_icb_rsp_rdata (m_icb_rsp_rdata),
    .m_icb_rsp_err   (m_icb_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        exp_q[$];
  txn_t        obs_q[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem[a];
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_err"},   err, 0);
    check({tag, "_valid"}, m_icb_cmd_valid, 0);
    check({tag, "_read"},  m_icb_cmd_read, 0);
    check({tag, "_addr"},  m_icb_cmd_addr, 0);
    check({tag, "_wdata"}, m_icb_cmd_wdata, 0);
    check({tag, "_wmask"}, m_icb_cmd_wmask, 0);
    check({tag, "_rrdy"},  m_icb_rsp_ready, 0);
  endtask

  // One complete copy, stepped one cycle per negedge.
  //   stall   : cycles cmd_ready is held low before each command is taken
  //   rdly    : cycles from read handshake to rsp_valid
  //   err_idx : read index answered with rsp_err (-1 for none)
  //   rst_idx : read index whose wait state gets a reset (-1 for none)
  task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                          input int n, input int stall, input int rdly,
                          input int err_idx, input int rst_idx, input bit chk_timing);
    bit          exp_err = 0;
    bit          outstanding = 0;
    bit          prev_stalled = 0;
    bit          in_rst = 0;
    bit          ign_pending = 0;
    bit          stop = 0;
    int          rsp_cd = 0;
    int          stall_cnt = 0;
    int          rd_cnt = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          valid_cnt = 0;
    logic [31:0] rd_addr = '0;
    logic [31:0] sv_addr = '0;
    logic [31:0] sv_wdata = '0;
    logic [3:0]  sv_wmask = '0;
    bit          sv_read = 0;

    // Reference: word i reads src+i*B then writes that value to dst+i*B.
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = s + 32'(i * BYTES);
      if (!mem.exists(a)) mem[a] = $urandom;
    end
    ref_mem.delete();
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, b, v;
      a = s + 32'(i * BYTES);
      b = d + 32'(i * BYTES);
      exp_q.push_back('{rd: 1'b1, addr: a, data: 32'h0});
      if (i == rst_idx) break;
`ifdef ICB_DMA_ERR_ABORT_EN
      if (i == err_idx) begin
        exp_err = 1;
        break;
      end
`endif
      v = ref_rd(a);
      exp_q.push_back('{rd: 1'b0, addr: b, data: v});
      ref_mem[b] = v;
    end

    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = 16'(n);
    m_icb_cmd_ready = 1'b0; m_icb_rsp_valid = 1'b0; m_icb_rsp_err = 1'b0;

    for (int cyc = 1; cyc <= LIMIT && !stop; cyc++) begin
      @(negedge clk);
      if (in_rst) begin
        check_outputs_zero({name, "_postrst"});
        check({name, "_rst_nodone"}, done_cnt, 0);
        rst_n = 1'b1;
        start = 1'b0;
        stop  = 1;
      end else if (ign_pending) begin
        check({name, "_done_1cyc"}, done, 0);
        check({name, "_done_ign_start"}, busy, 0);
        start = 1'b0;
        stop  = 1;
      end else begin
        // Observations of the current cycle.
        if (busy) busy_cnt++;
        if (m_icb_cmd_valid) valid_cnt++;
        check({name, "_rsp_ready"}, m_icb_rsp_ready, outstanding);
        if (outstanding) check({name, "_one_outstanding"}, m_icb_cmd_valid, 0);
        if (prev_stalled) begin
          check({name, "_stable_valid"}, m_icb_cmd_valid, 1);
          check({name, "_stable_addr"},  m_icb_cmd_addr, sv_addr);
          check({name, "_stable_read"},  m_icb_cmd_read, sv_read);
          check({name, "_stable_wdata"}, m_icb_cmd_wdata, sv_wdata);
          check({name, "_stable_wmask"}, m_icb_cmd_wmask, sv_wmask);
        end

        // Garbage start while busy must not disturb the copy.
        if (busy && ($urandom_range(0, 1) == 1)) begin
          start = 1'b1; src_addr = $urandom; dst_addr = $urandom; len = 16'($urandom);
        end else begin
          start = 1'b0;
        end

        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check({name, "_err"}, err, exp_err);
          // Start during the done cycle must be ignored.
          start = 1'b1; src_addr = $urandom; dst_addr = $urandom; len = 16'd5;
          ign_pending = 1;
        end

        if (rst_idx >= 0 && outstanding && rd_cnt == rst_idx + 1) begin
          rst_n = 1'b0;
          in_rst = 1;
          outstanding = 0;
          m_icb_rsp_valid = 1'b0;
          m_icb_cmd_ready = 1'b0;
        end else begin
          // Response channel.
          m_icb_rsp_valid = 1'b0;
          m_icb_rsp_err   = 1'b0;
          m_icb_rsp_rdata = $urandom;
          if (outstanding) begin
            rsp_cd--;
            if (rsp_cd == 0) begin
              m_icb_rsp_valid = 1'b1;
              m_icb_rsp_rdata = mem[rd_addr];
              m_icb_rsp_err   = (rd_cnt - 1 == err_idx);
              outstanding = 0;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            // Stray responses outside the wait state must be ignored.
            m_icb_rsp_valid = 1'b1;
            m_icb_rsp_err   = 1'($urandom);
          end

          // Command channel.
          if (m_icb_cmd_valid) begin
            if (stall_cnt < stall) begin
              m_icb_cmd_ready = 1'b0;
              stall_cnt++;
            end else begin
              m_icb_cmd_ready = 1'b1;
            end
          end else begin
            m_icb_cmd_ready = 1'($urandom);
          end
          prev_stalled = m_icb_cmd_valid && !m_icb_cmd_ready;
          sv_addr = m_icb_cmd_addr; sv_read = m_icb_cmd_read;
          sv_wdata = m_icb_cmd_wdata; sv_wmask = m_icb_cmd_wmask;
          if (m_icb_cmd_valid && m_icb_cmd_ready) begin
            stall_cnt = 0;
            if (m_icb_cmd_read) begin
              obs_q.push_back('{rd: 1'b1, addr: m_icb_cmd_addr, data: 32'h0});
              outstanding = 1;
              rsp_cd = rdly;
              rd_addr = m_icb_cmd_addr;
              rd_cnt++;
            end else begin
              obs_q.push_back('{rd: 1'b0, addr: m_icb_cmd_addr, data: m_icb_cmd_wdata});
              check({name, "_wmask"}, m_icb_cmd_wmask, 4'hF);
              mem[m_icb_cmd_addr] = m_icb_cmd_wdata;
            end
          end
        end
      end
    end

    m_icb_cmd_ready = 1'b0;
    m_icb_rsp_valid = 1'b0;
    m_icb_rsp_err   = 1'b0;
    start           = 1'b0;
    rst_n           = 1'b1;

    check({name, "_finished"}, stop, 1);
    check({name, "_done_cnt"}, done_cnt, (rst_idx >= 0) ? 0 : 1);
    check({name, "_txn_cnt"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_t%0d_rd", name, i),   obs_q[i].rd,   exp_q[i].rd);
      check($sformatf("%s_t%0d_addr", name, i), obs_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_t%0d_data", name, i), obs_q[i].data, exp_q[i].data);
    end
    if (chk_timing) begin
      check({name, "_busy_cycles"}, busy_cnt, 4 * n);
      check({name, "_done_cycle"}, done_cyc, (n == 0) ? 1 : 4 * n + 1);
    end
    if (n == 0) check({name, "_no_cmd"}, valid_cnt, 0);
  endtask

  initial begin
    logic [31:0] basic [4];
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    m_icb_cmd_ready = 1'b0; m_icb_rsp_valid = 1'b0;
    m_icb_rsp_rdata = '0; m_icb_rsp_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Basic copy with known data.
    basic[0] = 32'h11223344; basic[1] = 32'h55667788;
    basic[2] = 32'h99AABBCC; basic[3] = 32'hDDEEFF00;
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = basic[i];
    run_copy("basic", 32'h100, 32'h200, 4, 0, 2, -1, -1, 1);
    for (int i = 0; i < 4; i++)
      check($sformatf("basic_dst%0d", i), mem[32'h200 + 32'(4 * i)], basic[i]);

    run_copy("zero_len", 32'h300, 32'h400, 0, 0, 2, -1, -1, 1);
    run_copy("backpressure", 32'h500, 32'h600, 2, 3, 2, -1, -1, 0);

    run_copy("wrap", 32'hFFFFFFFC, 32'h700, 2, 0, 2, -1, -1, 1);
    if (obs_q.size() > 2) check("wrap_rd2_addr", obs_q[2].addr, 32'h0);
    else check("wrap_rd2_present", obs_q.size(), 4);

    // Error response on the first read; aborts only when the feature is built in.
    run_copy("rsp_err", 32'h800, 32'h900, 3, 0, 2, 0, -1, 0);

    run_copy("rst_mid", 32'hA00, 32'hB00, 4, 0, 2, -1, 1, 0);
    run_copy("after_rst", 32'hC00, 32'hD00, 3, 0, 2, -1, -1, 1);

    for (int k = 0; k < 20; k++) begin
      int n, st, rd, ei;
      logic [31:0] s, d;
      n  = $urandom_range(1, 6);
      st = $urandom_range(0, 3);
      rd = $urandom_range(1, 4);
      ei = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      s  = $urandom & 32'hFFFF_FFFC;
      d  = $urandom & 32'hFFFF_FFFC;
      run_copy($sformatf("rand%0d", k), s, d, n, st, rd, ei, -1, (st == 0 && rd == 2 && ei < 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icb_dma_copy.md
ICB_DMA_COPY -- requirements
Module: icb_dma_copy

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  request to begin a copy, sampled only in IDLE
- src_addr  in  ADDR_W  source byte address, captured on accepted start
- dst_addr  in  ADDR_W  destination byte address, captured on accepted start
- len  in  16  number of WIDTH-bit words to copy, captured on accepted start
- busy  out  1  copy in progress
- done  out  1  one-cycle completion pulse
- err  out  1  completion status, valid while done=1
- m_icb_cmd_valid  out  1  ICB command valid
- m_icb_cmd_ready  in  1  ICB command ready
- m_icb_cmd_addr  out  ADDR_W  ICB command byte address
- m_icb_cmd_read  out  1  1 = read, 0 = write
- m_icb_cmd_wdata  out  WIDTH  write data
- m_icb_cmd_wmask  out  WIDTH/8  byte-enable write mask
- m_icb_rsp_valid  in  1  read response valid
- m_icb_rsp_ready  out  1  read response ready
- m_icb_rsp_rdata  in  WIDTH  read data
- m_icb_rsp_err  in  1  read response error

Function
REQ-004 SHALL implement an FSM with states IDLE, RD_CMD, RD_WAIT, WR_CMD, DONE.
REQ-005 IDLE: start=1 and len!=0 SHALL capture src/dst/len and go to RD_CMD; start=1 and len=0 SHALL go to DONE with no bus traffic.
REQ-006 RD_CMD SHALL drive cmd_valid=1, read=1, addr=current src; cmd_valid=1 && cmd_ready=1 SHALL go to RD_WAIT.
REQ-007 RD_WAIT SHALL drive rsp_ready=1; rsp_valid=1 SHALL latch rdata and go to WR_CMD.
REQ-008 WR_CMD SHALL drive cmd_valid=1, read=0, addr=current dst, wdata=latched word, wmask=all ones.
REQ-009 On WR_CMD handshake: if words remaining is 1, SHALL go to DONE; otherwise SHALL advance both addresses by WIDTH/8 and go to RD_CMD.
REQ-010 Write completion SHALL be the command handshake; no write response is expected or consumed.
REQ-011 Address increments SHALL wrap modulo 2^ADDR_W.
REQ-012 At most one ICB transaction SHALL be outstanding at any time.
REQ-013 cmd_valid, once asserted, SHALL hold with stable addr, read, wdata, and wmask until the handshake.
REQ-014 rsp_ready SHALL be 0 outside RD_WAIT; rsp_valid outside RD_WAIT SHALL be ignored.
REQ-015 busy SHALL be 1 exactly in RD_CMD, RD_WAIT, and WR_CMD.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE; start in DONE SHALL be ignored.
REQ-017 start while busy SHALL be ignored and SHALL NOT alter captured parameters.
REQ-018 With an always-ready slave returning rsp_valid two cycles after the read handshake, each word SHALL cost exactly 4 cycles.

Reset
REQ-019 rst_n=0 at a clock edge SHALL force IDLE and clear busy, done, err, cmd_valid, rsp_ready, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, and all counters to 0.
REQ-020 Reset mid-copy SHALL abandon the transfer without a done pulse; outputs SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-021 With macro ICB_DMA_ERR_ABORT_EN defined: rsp_err=1 in RD_WAIT SHALL skip the write, go to DONE, and set err=1 there.
REQ-022 Without ICB_DMA_ERR_ABORT_EN: rsp_err SHALL be ignored, the returned data SHALL be written normally, and err SHALL be constant 0.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Basic copy: src 0x100 holds 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00; start with dst=0x200, len=4, always-ready slave -> dst words match; busy high exactly 16 cycles; one done pulse; err=0.
- Zero length: start with len=0 -> done pulse on the next cycle; no cmd_valid ever; busy stays 0.
- Backpressure: cmd_ready low for 3 cycles per command, len=2 -> cmd fields stable while stalled; data copied correctly.
- Address wrap: src=0xFFFFFFFC, len=2 -> second read addr 0x00000000.
- Error response with ICB_DMA_ERR_ABORT_EN defined, rsp_err=1 on word 1 of len=3 -> no writes issued; done=1 with err=1.
- Reset mid-copy: rst_n=0 in RD_WAIT of word 2 -> next cycle IDLE, all outputs 0, no done pulse; a new start then completes normally.
